// File: rtl/i2s_tx_frame_fifo_if.sv
// i2s_tx_frame_fifo_if: frame stream in, sample request/response out for the I2S tx frame FIFO
interface i2s_tx_frame_fifo_if #(
  parameter int DW    = 24,
  parameter int DEPTH = 16
);
  logic                     s_valid;
  logic                     s_ready;
  logic [DW-1:0]            s_left;
  logic [DW-1:0]            s_right;
  logic                     rd_en;
  logic                     o_valid;
  logic [DW-1:0]            o_sample;
  logic [$clog2(DEPTH):0]   level;
  logic                     underrun;
  modport master (
    output s_valid, s_left, s_right, rd_en,
    input  s_ready, o_valid, o_sample, level, underrun
  );
  modport slave (
    input  s_valid, s_left, s_right, rd_en,
    output s_ready, o_valid, o_sample, level, underrun
  );
endinterface

// File: rtl/i2s_tx_frame_fifo.sv
// i2s_tx_frame_fifo: stereo frame FIFO serving L then R samples, muting on underrun
// Optional underrun_count port enabled by I2S_TX_FIFO_UNDERRUN_CTR_EN
module i2s_tx_frame_fifo #(
  parameter int DW    = 24,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  i2s_tx_frame_fifo_if.slave bus
`ifdef I2S_TX_FIFO_UNDERRUN_CTR_EN
  ,
  output logic [15:0] underrun_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [1:0] {PH_L, PH_R, PH_MUTE} ph_t;
  ph_t ph;
  logic [2*DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic push, pop, empty;
  assign bus.s_ready = bus.level != LW'(DEPTH);
  assign push  = bus.s_valid && bus.s_ready;
  assign pop   = bus.rd_en && ph == PH_R;
  assign empty = bus.level == '0;
  always_ff @(posedge clk)
    if (push && !rst) mem[wp] <= {bus.s_left, bus.s_right};
  // A frame is popped only when its right sample is issued, so level covers PH_R.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp           <= '0;
      rp           <= '0;
      ph           <= PH_L;
      bus.level    <= '0;
      bus.o_valid  <= 1'b0;
      bus.o_sample <= '0;
      bus.underrun <= 1'b0;
    end else begin
      bus.o_valid  <= bus.rd_en;
      bus.underrun <= bus.rd_en && ph == PH_L && empty;
      bus.level    <= bus.level + LW'(push) - LW'(pop);
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      if (bus.rd_en) begin
        case (ph)
          PH_L: begin
            bus.o_sample <= empty ? '0 : mem[rp][2*DW-1:DW];
            ph           <= empty ? PH_MUTE : PH_R;
          end
          PH_R: begin
            bus.o_sample <= mem[rp][DW-1:0];
            ph           <= PH_L;
          end
          default: begin
            bus.o_sample <= '0;
            ph           <= PH_L;
          end
        endcase
      end
    end
  end
`ifdef I2S_TX_FIFO_UNDERRUN_CTR_EN
  always_ff @(posedge clk)
    if (rst) underrun_count <= '0;
    else if (bus.underrun && underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
`endif
endmodule
